// File: rtl/led_flow_ctrl.sv
// led_flow_ctrl: LED chaser with four flow modes and a
// debounced mode key, stepped by an asynchronous toggle.
//
// Parameters:
//   LED_W   - LED bus width (>= 2)
//   DB_MAX  - debounce terminal count in sys_clk cycles
// Ports:
//   sys_clk - clock, rising edge
//   sys_rst - async active-high reset
//   step_in - async toggling level, each edge is a step
//   key_in  - raw active-low push button
//   led_out - registered LED pattern, 1 = lit
//   mode    - registered mode: 0 LEFT 1 RIGHT
//             2 BOUNCE 3 BLINK
module led_flow_ctrl #(
  parameter int          LED_W  = 4,
  parameter logic [19:0] DB_MAX = 20'd999_999
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             step_in,
  input  logic             key_in,
  output logic [LED_W-1:0] led_out,
  output logic [1:0]       mode
);

  localparam logic [1:0] M_LEFT   = 2'd0;
  localparam logic [1:0] M_RIGHT  = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;
  localparam logic [1:0] M_BLINK  = 2'd3;

  localparam logic [LED_W-1:0] LSB =
    {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] MSB =
    {1'b1, {(LED_W-1){1'b0}}};

  function automatic logic [LED_W-1:0] init_pat(
    input logic [1:0] m
  );
    logic [LED_W-1:0] p;
    p = LSB;
    case (m)
      M_RIGHT: p = MSB;
      M_BLINK: p = '0;
      default: p = LSB;
    endcase
    return p;
  endfunction

  // step_in: [0],[1] synchronize, [2] is history
  logic [2:0] st_sync;
  logic [1:0] arm_cnt;
  logic       armed;
  logic       step_pls;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      st_sync <= '0;
    end else begin
      st_sync <= {st_sync[1:0], step_in};
    end
  end

  // Arm only once the synchronizer holds post-reset
  // samples, so a level held across reset is no step.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 2'd1;
      armed   <= (arm_cnt == 2'd2);
    end
  end

  assign step_pls = armed & (st_sync[1] ^ st_sync[2]);

  logic [1:0]  k_sync;
  logic        k_stable;
  logic [19:0] db_cnt;
  logic        db_hit;
  logic        key_pls;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      k_sync <= 2'b11;
    end else begin
      k_sync <= {k_sync[0], key_in};
    end
  end

  assign db_hit = (db_cnt == DB_MAX);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      k_stable <= 1'b1;
      db_cnt   <= '0;
    end else if (k_sync[1] == k_stable) begin
      db_cnt   <= '0;
    end else if (db_hit) begin
      k_stable <= k_sync[1];
      db_cnt   <= '0;
    end else begin
      db_cnt   <= db_cnt + 20'd1;
    end
  end

  // Press only: stable level about to fall 1 -> 0
  assign key_pls = k_stable & ~k_sync[1] & db_hit;

  logic       dir;
  logic [1:0] mode_nx;

  assign mode_nx = mode + 2'd1;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode    <= M_LEFT;
      led_out <= LSB;
      dir     <= 1'b0;
    end else if (key_pls) begin
      // mode change wins; a coincident step is dropped
      mode    <= mode_nx;
      led_out <= init_pat(mode_nx);
      dir     <= 1'b0;
    end else if (step_pls) begin
      case (mode)
        M_LEFT: led_out <=
          {led_out[LED_W-2:0], led_out[LED_W-1]};
        M_RIGHT: led_out <=
          {led_out[0], led_out[LED_W-1:1]};
        M_BOUNCE: begin
          // flip as the end bit is reached so it
          // is lit for a single step only
          if (!dir) begin
            led_out <= led_out << 1;
            if (led_out[LED_W-2]) dir <= 1'b1;
          end else begin
            led_out <= led_out >> 1;
            if (led_out[1]) dir <= 1'b0;
          end
        end
        default: led_out <= ~led_out;
      endcase
    end
  end

endmodule

// File: tb/tb_led_flow_ctrl.sv
// tb_led_flow_ctrl: directed bench with a behavioural
// model compared against led_out/mode every cycle.
module tb_led_flow_ctrl;

  localparam int W  = 4;
  localparam int DB = 15;

  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b1;
  logic         step_in = 1'b1;
  logic         key_in  = 1'b1;
  logic [W-1:0] led_out;
  logic [1:0]   mode;

  led_flow_ctrl #(
    .LED_W  (W),
    .DB_MAX (20'(DB))
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .step_in (step_in),
    .key_in  (key_in),
    .led_out (led_out),
    .mode    (mode)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Model: mode, lit position, bounce direction,
  // blink phase; events scheduled by due edge count.
  int   m_mode, m_pos, m_dir, m_n, m_kcnt, m_kdue;
  bit   m_lit, stp;
  logic m_prev, m_kst;
  int   sq[$];

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_mode = 0; m_pos = 0; m_dir = 0; m_lit = 0;
      m_n = 0; m_kcnt = 0; m_kdue = -1;
      m_prev = 1'b0; m_kst = 1'b1;
      sq.delete();
    end else begin
      m_n++;
      if (step_in !== m_prev) begin
        sq.push_back(m_n + 2);
        m_prev = step_in;
      end
      if (key_in !== m_kst) m_kcnt++;
      else m_kcnt = 0;
      if (m_kcnt == DB + 1) begin
        m_kst  = key_in;
        m_kcnt = 0;
        if (!key_in) m_kdue = m_n + 2;
      end
      stp = 0;
      if (sq.size() > 0 && sq[0] == m_n) begin
        void'(sq.pop_front());
        stp = (m_n > 3);
      end
      if (m_kdue == m_n) begin
        m_mode = (m_mode + 1) % 4;
        m_pos  = (m_mode == 1) ? W - 1 : 0;
        m_dir  = 0;
        m_lit  = 0;
      end else if (stp) begin
        case (m_mode)
          0: m_pos = (m_pos + 1) % W;
          1: m_pos = (m_pos + W - 1) % W;
          2: begin
            m_pos = m_dir ? m_pos - 1 : m_pos + 1;
            if (m_pos == W - 1) m_dir = 1;
            else if (m_pos == 0) m_dir = 0;
          end
          default: m_lit = !m_lit;
        endcase
      end
    end
  end

  function automatic logic [W-1:0] exp_led();
    if (m_mode == 3) return m_lit ? '1 : '0;
    return W'(1 << m_pos);
  endfunction

  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("model_led", led_out, exp_led());
      chk("model_mode", mode, m_mode);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic tog(input logic [W-1:0] exp);
    step_in = ~step_in;
    cyc(3);
    chk("step_led", led_out, exp);
    cyc(7);
  endtask

  task automatic press(
    input logic [1:0]   em,
    input logic [W-1:0] el
  );
    key_in = 1'b0;
    cyc(40);
    chk("press_mode", mode, em);
    chk("press_led", led_out, el);
    key_in = 1'b1;
    cyc(30);
  endtask

  initial begin
    cyc(1);
    chk_en = 1;
    cyc(3);
    sys_rst = 1'b0;
    cyc(20);
    chk("rst_led", led_out, 4'b0001);
    chk("rst_mode", mode, 2'd0);

    tog(4'b0010); tog(4'b0100); tog(4'b1000);
    tog(4'b0001); tog(4'b0010);

    key_in = 1'b0; cyc(10);
    key_in = 1'b1; cyc(30);
    chk("glitch_mode", mode, 2'd0);
    chk("glitch_led", led_out, 4'b0010);

    key_in = 1'b0;
    cyc(40);
    chk("hold_mode", mode, 2'd1);
    chk("hold_led", led_out, 4'b1000);
    key_in = 1'b1; cyc(1);
    key_in = 1'b0; cyc(1);
    key_in = 1'b1; cyc(1);
    key_in = 1'b0; cyc(1);
    key_in = 1'b1; cyc(40);
    chk("rel_mode", mode, 2'd1);
    chk("rel_led", led_out, 4'b1000);

    tog(4'b0100);
    press(2'd2, 4'b0001);
    tog(4'b0010); tog(4'b0100); tog(4'b1000);
    tog(4'b0100); tog(4'b0010); tog(4'b0001);
    tog(4'b0010); tog(4'b0100);

    press(2'd3, 4'b0000);
    tog(4'b1111); tog(4'b0000);
    press(2'd0, 4'b0001);
    tog(4'b0010); tog(4'b0100);

    key_in = 1'b0;
    cyc(15);
    step_in = ~step_in;
    cyc(25);
    chk("coin_mode", mode, 2'd1);
    chk("coin_led", led_out, 4'b1000);
    key_in = 1'b1;
    cyc(30);
    chk("coin_hold", led_out, 4'b1000);

    step_in = ~step_in;
    @(posedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    chk("async_led", led_out, 4'b0001);
    chk("async_mode", mode, 2'd0);
    cyc(2);
    sys_rst = 1'b0;
    cyc(20);
    chk("post_led", led_out, 4'b0001);
    chk("post_mode", mode, 2'd0);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
